// File: rtl/regfile_write_scheduler.sv
// Write-side scheduler for a 2-write-port register file: buffers results from two execution
// channels in order and drains up to two per cycle, never targeting one register twice in a cycle.
module regfile_write_scheduler #(
   parameter  int DEPTH  = 8,
   parameter  int ADDR_W = 5,
   parameter  int DATA_W = 16,
   localparam int PKT_W  = ADDR_W + DATA_W,
   localparam int CNT_W  = $clog2(DEPTH) + 1,
   localparam int NREG   = 1 << ADDR_W
) (
   input  logic              iClock,
   input  logic              iReset,
   input  logic              iResultValidA,
   input  logic [PKT_W-1:0]  iResultA,
   input  logic              iResultValidB,
   input  logic [PKT_W-1:0]  iResultB,
   output logic              oResultReady,
   input  logic              iStall,
   output logic              oWritePort1,
   output logic [PKT_W-1:0]  oRegWrite1,
   output logic              oWritePort2,
   output logic [PKT_W-1:0]  oRegWrite2,
   output logic [NREG-1:0]   oPending,
   output logic [CNT_W-1:0]  oCount
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PKT_W-1:0] mem_q [DEPTH];
   logic [PKT_W-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic             push_a, push_b, we1, we2;
   logic [PTR_W-1:0] rptr_nxt, wptr_b;
   logic [PKT_W-1:0] head_pkt, next_pkt;

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      oResultReady = (count_q <= CNT_W'(DEPTH - 2));
      push_a       = iResultValidA && oResultReady;
      push_b       = iResultValidB && oResultReady;

      rptr_nxt = rptr_q + PTR_W'(1);
      head_pkt = mem_q[rptr_q];
      next_pkt = mem_q[rptr_nxt];

      // The younger of a same-register pair waits a cycle so the last write wins.
      we1 = !iStall && (count_q != '0);
      we2 = !iStall && (count_q >= CNT_W'(2))
            && (head_pkt[PKT_W-1:DATA_W] != next_pkt[PKT_W-1:DATA_W]);

      wptr_b = wptr_q + PTR_W'(push_a);

      mem_d   = mem_q;
      valid_d = valid_q;
      if (we1) valid_d[rptr_q]   = 1'b0;
      if (we2) valid_d[rptr_nxt] = 1'b0;
      if (push_a) begin
         mem_d[wptr_q]   = iResultA;
         valid_d[wptr_q] = 1'b1;
      end
      if (push_b) begin
         mem_d[wptr_b]   = iResultB;
         valid_d[wptr_b] = 1'b1;
      end

      wptr_d  = wptr_q + PTR_W'(push_a) + PTR_W'(push_b);
      rptr_d  = rptr_q + PTR_W'(we1) + PTR_W'(we2);
      count_d = count_q + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(we1) - CNT_W'(we2);

      oPending = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i]) oPending[mem_q[i][PKT_W-1:DATA_W]] = 1'b1;
      end

      oWritePort1 = we1;
      oWritePort2 = we2;
      oRegWrite1  = we1 ? head_pkt : '0;
      oRegWrite2  = we2 ? next_pkt : '0;
      oCount      = count_q;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         valid_q <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // NOTE: the payload array is not reset; valid bits and count alone decide what is live.
   always_ff @(posedge iClock) begin
      mem_q <= mem_d;
   end

endmodule
